lab_gate_arbiter: RTL and testbench

Front-end controller for the shared lab occupancy unit (Mera/Digital counters). Two card-reader gates (A, B) issue entry/exit requests. The block arbitrates them round-robin and serialises one command at a time to the occupancy unit. It returns the verdict to the requesting gate and drives a timed door-open strobe per lab.

---
 rtl/lab_gate_arbiter.sv | 162 ++++++++++++++++
 tb/tb_lab_gate_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lab_gate_arbiter.sv
// Lab gate arbiter: round-robin between two card-reader gates, serialises commands to the occupancy unit.
// Optional EXIT_PRIORITY_EN: when both gates request, an exit (mode 00) beats a non-exit.
module lab_gate_arbiter #(
  parameter int DOOR_CYCLES = 4,
  parameter int TIMER_W     = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       reqA,
  input  logic [4:0] codeA,
  input  logic       labA,
  input  logic [1:0] modeA,
  input  logic       reqB,
  input  logic [4:0] codeB,
  input  logic       labB,
  input  logic [1:0] modeB,
  output logic       ackA,
  output logic       ackB,
  output logic       resp_ok,
  output logic       resp_warn,
  output logic       occ_valid,
  output logic [4:0] occ_code,
  output logic       occ_lab,
  output logic [1:0] occ_mode,
  input  logic       occ_unlock,
  input  logic       occ_warn,
  output logic       doorMera,
  output logic       doorDigital,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DOOR} stateT;

  stateT              state;
  logic               rrPtr;       // 0: gate A wins a tie, 1: gate B wins
  logic               latB;
  logic [4:0]         latCode;
  logic               latLab;
  logic [1:0]         latMode;
  logic [TIMER_W-1:0] timer;

  logic       pickB;
  logic       useRr;
  logic [4:0] selCode;
  logic       selLab;
  logic [1:0] selMode;

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pickB = 1'b0;
    useRr = 1'b0;
    if (reqA && reqB) begin
`ifdef EXIT_PRIORITY_EN
      if (modeA == 2'b00 && modeB != 2'b00) begin
        pickB = 1'b0;
      end else if (modeB == 2'b00 && modeA != 2'b00) begin
        pickB = 1'b1;
      end else begin
        pickB = rrPtr;
        useRr = 1'b1;
      end
`else
      pickB = rrPtr;
      useRr = 1'b1;
`endif
    end else begin
      pickB = reqB;
    end
    selCode = pickB ? codeB : codeA;
    selLab  = pickB ? labB  : labA;
    selMode = pickB ? modeB : modeA;
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      rrPtr       <= 1'b0;
      latB        <= 1'b0;
      latCode     <= '0;
      latLab      <= 1'b0;
      latMode     <= '0;
      timer       <= '0;
      ackA        <= 1'b0;
      ackB        <= 1'b0;
      resp_ok     <= 1'b0;
      resp_warn   <= 1'b0;
      occ_valid   <= 1'b0;
      occ_code    <= '0;
      occ_lab     <= 1'b0;
      occ_mode    <= '0;
      doorMera    <= 1'b0;
      doorDigital <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqA || reqB) begin
            latB    <= pickB;
            latCode <= selCode;
            latLab  <= selLab;
            latMode <= selMode;
            if (useRr) rrPtr <= ~rrPtr;
            if (selMode[1]) begin
              // Idle mode: answer directly, occupancy unit is never consulted.
              ackA      <= ~pickB;
              ackB      <= pickB;
              resp_ok   <= 1'b0;
              resp_warn <= 1'b0;
              state     <= RESP;
            end else begin
              occ_valid <= 1'b1;
              occ_code  <= selCode;
              occ_lab   <= selLab;
              occ_mode  <= selMode;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          occ_valid <= 1'b0;
          occ_code  <= '0;
          occ_lab   <= 1'b0;
          occ_mode  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          resp_ok   <= occ_unlock;
          resp_warn <= occ_warn;
          ackA      <= ~latB;
          ackB      <= latB;
          state     <= RESP;
        end
        RESP: begin
          ackA      <= 1'b0;
          ackB      <= 1'b0;
          resp_ok   <= 1'b0;
          resp_warn <= 1'b0;
          if (resp_ok) begin
            timer       <= TIMER_W'(DOOR_CYCLES);
            doorMera    <= latLab;
            doorDigital <= ~latLab;
            state       <= DOOR;
          end else begin
            state <= IDLE;
          end
        end
        DOOR: begin
          timer <= timer - 1'b1;
          if (timer == TIMER_W'(1)) begin
            doorMera    <= 1'b0;
            doorDigital <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab_gate_arbiter.sv
// Directed self-checking bench for lab_gate_arbiter; all checks sampled on the falling clock edge.
module tb_lab_gate_arbiter;

  localparam int DOOR_CYCLES = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       reqA, labA, reqB, labB;
  logic [4:0] codeA, codeB;
  logic [1:0] modeA, modeB;
  logic       ackA, ackB, resp_ok, resp_warn;
  logic       occ_valid, occ_lab;
  logic [4:0] occ_code;
  logic [1:0] occ_mode;
  logic       occ_unlock, occ_warn;
  logic       doorMera, doorDigital, busy;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  lab_gate_arbiter #(.DOOR_CYCLES(DOOR_CYCLES), .TIMER_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .reqA(reqA), .codeA(codeA), .labA(labA), .modeA(modeA),
    .reqB(reqB), .codeB(codeB), .labB(labB), .modeB(modeB),
    .ackA(ackA), .ackB(ackB), .resp_ok(resp_ok), .resp_warn(resp_warn),
    .occ_valid(occ_valid), .occ_code(occ_code), .occ_lab(occ_lab), .occ_mode(occ_mode),
    .occ_unlock(occ_unlock), .occ_warn(occ_warn),
    .doorMera(doorMera), .doorDigital(doorDigital), .busy(busy)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at the falling edge of the cycle in which the winning request is latched.
  task automatic txn(input logic gateB, input logic [4:0] code, input logic lab,
                     input logic [1:0] mode, input logic ok, input logic warn);
    @(negedge CLK);
    check("issue_valid", {7'd0, occ_valid}, 8'd1);
    check("issue_code", {3'd0, occ_code}, {3'd0, code});
    check("issue_lab", {7'd0, occ_lab}, {7'd0, lab});
    check("issue_mode", {6'd0, occ_mode}, {6'd0, mode});
    check("issue_busy", {7'd0, busy}, 8'd1);
    @(negedge CLK);
    check("wait_valid", {7'd0, occ_valid}, 8'd0);
    check("wait_ack", {6'd0, ackA, ackB}, 8'd0);
    @(negedge CLK);
    check("resp_ack", {6'd0, ackA, ackB}, {6'd0, ~gateB, gateB});
    check("resp_ok", {7'd0, resp_ok}, {7'd0, ok});
    check("resp_warn", {7'd0, resp_warn}, {7'd0, warn});
    check("resp_occ_code", {3'd0, occ_code}, 8'd0);
    if (gateB) reqB = 1'b0;
    else       reqA = 1'b0;
  endtask

  // Door window followed by the first IDLE cycle.
  task automatic door_phase(input logic lab);
    for (int i = 0; i < DOOR_CYCLES; i++) begin
      @(negedge CLK);
      check("door_open", {6'd0, doorMera, doorDigital}, {6'd0, lab, ~lab});
      check("door_quiet", {5'd0, ackA, ackB, resp_ok}, 8'd0);
    end
    @(negedge CLK);
    check("door_closed", {5'd0, doorMera, doorDigital, busy}, 8'd0);
  endtask

  initial begin
    RST = 1'b1;
    reqA = 1'b0; codeA = '0; labA = 1'b0; modeA = 2'b11;
    reqB = 1'b0; codeB = '0; labB = 1'b0; modeB = 2'b11;
    occ_unlock = 1'b1; occ_warn = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("reset_outs", {ackA, ackB, resp_ok, resp_warn, occ_valid, doorMera, doorDigital, busy}, 8'd0);
    check("reset_occ", {1'b0, occ_code, occ_mode}, 8'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Single enter to Mera, unlocked.
    reqA = 1'b1; codeA = 5'h00; labA = 1'b1; modeA = 2'b01;
    txn(1'b0, 5'h00, 1'b1, 2'b01, 1'b1, 1'b0);
    door_phase(1'b1);

    // Tie: A wins, then B (tie again because A re-requests), then A on the third tie.
    reqA = 1'b1; codeA = 5'h03; labA = 1'b0; modeA = 2'b01;
    reqB = 1'b1; codeB = 5'h1C; labB = 1'b0; modeB = 2'b01;
    txn(1'b0, 5'h03, 1'b0, 2'b01, 1'b1, 1'b0);
    reqA = 1'b1; codeA = 5'h07;
    door_phase(1'b0);
    txn(1'b1, 5'h1C, 1'b0, 2'b01, 1'b1, 1'b0);
    reqB = 1'b1; codeB = 5'h15;
    door_phase(1'b0);
    txn(1'b0, 5'h07, 1'b0, 2'b01, 1'b1, 1'b0);
    door_phase(1'b0);
    txn(1'b1, 5'h15, 1'b0, 2'b01, 1'b1, 1'b0);
    door_phase(1'b0);

    // Idle mode from B: immediate ack, nothing issued, no door.
    reqB = 1'b1; codeB = 5'h1F; labB = 1'b1; modeB = 2'b10;
    @(negedge CLK);
    check("idle_ack", {6'd0, ackA, ackB}, 8'd1);
    check("idle_resp", {6'd0, resp_ok, resp_warn}, 8'd0);
    check("idle_no_issue", {7'd0, occ_valid}, 8'd0);
    reqB = 1'b0;
    @(negedge CLK);
    check("idle_after", {4'd0, occ_valid, doorMera, doorDigital, busy}, 8'd0);

    // Refused with warning: no door, back to IDLE next cycle.
    occ_unlock = 1'b0; occ_warn = 1'b1;
    reqA = 1'b1; codeA = 5'h0A; labA = 1'b0; modeA = 2'b01;
    txn(1'b0, 5'h0A, 1'b0, 2'b01, 1'b0, 1'b1);
    @(negedge CLK);
    check("refuse_after", {5'd0, doorMera, doorDigital, busy}, 8'd0);
    occ_unlock = 1'b1; occ_warn = 1'b0;

    // Reset during door window (timer=2), then a fresh request from B.
    reqA = 1'b1; codeA = 5'h12; labA = 1'b1; modeA = 2'b01;
    txn(1'b0, 5'h12, 1'b1, 2'b01, 1'b1, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check("pre_reset_door", {6'd0, doorMera, busy}, 8'd3);
    RST = 1'b1;
    #1;
    check("abort_door", {5'd0, doorMera, doorDigital, busy}, 8'd0);
    check("abort_ack", {6'd0, ackA, ackB}, 8'd0);
    @(negedge CLK);
    RST = 1'b0;
    reqB = 1'b1; codeB = 5'h11; labB = 1'b1; modeB = 2'b01;
    txn(1'b1, 5'h11, 1'b1, 2'b01, 1'b1, 1'b0);
    door_phase(1'b1);

    // Pointer at A; A enters while B exits.
    reqA = 1'b1; codeA = 5'h01; labA = 1'b0; modeA = 2'b01;
    reqB = 1'b1; codeB = 5'h02; labB = 1'b0; modeB = 2'b00;
`ifdef EXIT_PRIORITY_EN
    txn(1'b1, 5'h02, 1'b0, 2'b00, 1'b1, 1'b0);
    reqB = 1'b1; codeB = 5'h04; modeB = 2'b01;
    door_phase(1'b0);
    txn(1'b0, 5'h01, 1'b0, 2'b01, 1'b1, 1'b0);
    door_phase(1'b0);
    txn(1'b1, 5'h04, 1'b0, 2'b01, 1'b1, 1'b0);
    door_phase(1'b0);
`else
    txn(1'b0, 5'h01, 1'b0, 2'b01, 1'b1, 1'b0);
    door_phase(1'b0);
    txn(1'b1, 5'h02, 1'b0, 2'b00, 1'b1, 1'b0);
    door_phase(1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
